// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage: data first,
// fetch otherwise, with pipeline stall generation and a sticky bus-timeout trap.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic [1:0]  m_ctrl,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_done,
  output logic        stall_mem,
  output logic        stall_if,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  // Bus handshake: bus_req rises together with bus_addr/bus_we/bus_wdata and all
  // of them hold until a cycle with bus_ack; that edge completes the access and
  // drops bus_req. bus_ack seen while bus_req is low is ignored.

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMO_FULL = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] tmo_cnt;
  logic       start_data;
  logic       start_fetch;
  logic       acc_done;
  logic       tmo_hit;

  // Word addressing drops the byte offset bits of both request addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_addr[1:0], if_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_data  = 1'b0;
    start_fetch = 1'b0;
    acc_done    = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      IDLE: begin
        if ((m_ctrl != 2'b00) && !m_done) begin
          start_data = 1'b1;
          state_next = D_ACC;
        end else if (if_req && !if_valid) begin
          start_fetch = 1'b1;
          state_next  = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        // An ack on the last counted cycle still completes normally.
        if (bus_ack) begin
          acc_done   = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = ERR;
        end
      end
      ERR: state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_mem = 1'b0;
    stall_if  = 1'b0;
    if (reset) begin
      if (state == ERR) begin
        stall_mem = 1'b1;
        stall_if  = 1'b1;
      end else begin
        stall_mem = (m_ctrl != 2'b00) && !m_done;
        stall_if  = stall_mem || (if_req && !if_valid);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      m_rdata   <= '0;
      m_done    <= 1'b0;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      m_done <= 1'b0;
      // IF/ID captures the instruction on the first edge the pipeline is not frozen.
      if (!stall_mem) begin
        if_valid <= 1'b0;
      end
      if (start_data) begin
        bus_req   <= 1'b1;
        bus_we    <= m_ctrl[1];
        bus_addr  <= {m_addr[31:2], 2'b00};
        bus_wdata <= m_wdata;
        tmo_cnt   <= '0;
      end else if (start_fetch) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= {if_addr[31:2], 2'b00};
        tmo_cnt  <= '0;
      end
      if (acc_done) begin
        bus_req <= 1'b0;
        tmo_cnt <= '0;
        if (state == D_ACC) begin
          m_done <= 1'b1;
          if (!bus_we) begin
            m_rdata <= bus_rdata;
          end
        end else begin
          if_rdata <= bus_rdata;
          if_valid <= 1'b1;
        end
      end else if (tmo_hit) begin
        bus_req <= 1'b0;
        bus_err <= 1'b1;
        tmo_cnt <= TMO_FULL;
      end else if ((state == D_ACC) || (state == I_ACC)) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random pipeline/bus mix,
// scored against a word-memory reference model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic [1:0]  m_ctrl;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_done;
  logic        stall_mem;
  logic        stall_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  mem_port_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .m_ctrl(m_ctrl), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_done(m_done), .stall_mem(stall_mem), .stall_if(stall_if),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] bus_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] last_load = '0;

  logic slave_on = 1'b1;
  int   wait_min = 0;
  int   wait_max = 0;
  logic fetch_en = 1'b0;
  logic mon_en   = 1'b1;

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [29:0] w);
    return {w[15:0] ^ 16'hC3A5, ~w[15:0]};
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] w);
    if (bus_mem.exists(w)) return bus_mem[w];
    return imem_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return imem_word(w);
  endfunction

  // Reference model: loads return the model memory, stores update it and leave m_rdata alone.
  function automatic void push_data(input logic [1:0] ctrl, input logic [31:0] addr,
                                    input logic [31:0] wdata);
    if (ctrl[1]) ref_mem[addr[31:2]] = wdata;
    else last_load = ref_rd(addr[31:2]);
    exp_q.push_back(last_load);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    fetch_q.delete();
    last_load = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chk1({tag, "_bus_we"}, bus_we, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk1({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_m_rdata"}, m_rdata, 32'h0);
    chk1({tag, "_m_done"}, m_done, 1'b0);
    chk1({tag, "_bus_err"}, bus_err, 1'b0);
    chk1({tag, "_stall_mem"}, stall_mem, 1'b0);
    chk1({tag, "_stall_if"}, stall_if, 1'b0);
  endtask

  // Called at the start of a cycle; returns at the start of the cycle after m_done.
  task automatic run_op(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic got;
    m_ctrl = ctrl;
    m_addr = addr;
    m_wdata = wdata;
    push_data(ctrl, addr, wdata);
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = (m_done === 1'b1);
    end
    chk1("op_completes", got, 1'b1);
    cyc();
    m_ctrl = 2'b00;
  endtask

  // ---------------- bus slave ----------------
  initial begin
    int wait_left;
    logic waited;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic cap_we;
    wait_left = -1;
    waited = 1'b0;
    cap_addr = '0;
    cap_wdata = '0;
    cap_we = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (slave_on) begin
        bus_ack = 1'b0;
        if (bus_req !== 1'b1) begin
          wait_left = -1;
        end else begin
          if (wait_left < 0) begin
            wait_left = int'($urandom_range(wait_max, wait_min));
            waited = 1'b0;
            cap_addr = bus_addr;
            cap_wdata = bus_wdata;
            cap_we = bus_we;
          end else begin
            waited = 1'b1;
          end
          if (wait_left == 0) begin
            if (waited) begin
              chk("bus_addr_stable", bus_addr, cap_addr);
              chk("bus_wdata_stable", bus_wdata, cap_wdata);
              chk1("bus_we_stable", bus_we, cap_we);
            end
            chk("bus_addr_align", {30'b0, bus_addr[1:0]}, 32'h0);
            bus_ack = 1'b1;
            if (bus_we) begin
              bus_mem[bus_addr[31:2]] = bus_wdata;
              bus_rdata = $urandom;
            end else begin
              bus_rdata = bus_rd(bus_addr[31:2]);
            end
            wait_left = -1;
          end else begin
            wait_left--;
          end
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  // ---------------- fetch driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (fetch_en && if_valid === 1'b1 && stall_mem === 1'b0) begin
        cyc();
        if (fetch_en) begin
          if_addr = if_addr + 32'd4;
          fetch_q.push_back(imem_word(if_addr[31:2]));
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL m_done_spurious: got m_done=1 expected no completion at %0t", $time);
        end else begin
          chk("m_rdata", m_rdata, exp_q.pop_front());
        end
      end
      if (if_valid === 1'b1 && stall_mem === 1'b0) begin
        if (fetch_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_spurious: got if_valid=1 expected no instruction at %0t", $time);
        end else begin
          chk("if_rdata", if_rdata, fetch_q.pop_front());
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    reset = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    m_ctrl = 2'b01;
    m_addr = '0;
    m_wdata = '0;
    bus_mem[30'h401] = 32'hDEAD_BEEF;
    ref_mem[30'h401] = 32'hDEAD_BEEF;

    // Reset state; stalls are forced low even with a request present.
    @(negedge clk);
    chk1("rst_stall_mem_forced", stall_mem, 1'b0);
    @(negedge clk);
    m_ctrl = 2'b00;
    chk_all_zero("rst");
    cyc();
    reset = 1'b1;

    // Load with zero-wait ack.
    cyc();
    wait_min = 0; wait_max = 0;
    m_ctrl = 2'b01; m_addr = 32'h0000_1006;
    push_data(2'b01, 32'h0000_1006, 32'h0);
    @(negedge clk);
    chk1("ld_c0_stall_mem", stall_mem, 1'b1);
    chk1("ld_c0_bus_req", bus_req, 1'b0);
    cyc();
    @(negedge clk);
    chk1("ld_c1_bus_req", bus_req, 1'b1);
    chk("ld_c1_bus_addr", bus_addr, 32'h0000_1004);
    chk1("ld_c1_bus_we", bus_we, 1'b0);
    chk1("ld_c1_stall_mem", stall_mem, 1'b1);
    cyc();
    @(negedge clk);
    chk1("ld_c2_m_done", m_done, 1'b1);
    chk("ld_c2_m_rdata", m_rdata, 32'hDEAD_BEEF);
    chk1("ld_c2_stall_mem", stall_mem, 1'b0);
    chk1("ld_c2_stall_if", stall_if, 1'b0);
    cyc();
    m_ctrl = 2'b00;

    // Store with three wait cycles.
    cyc();
    wait_min = 3; wait_max = 3;
    m_ctrl = 2'b10; m_addr = 32'h0000_1008; m_wdata = 32'h1234_5678;
    push_data(2'b10, 32'h0000_1008, 32'h1234_5678);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      @(negedge clk);
      chk1("st_bus_req", bus_req, 1'b1);
      chk1("st_bus_we", bus_we, 1'b1);
      chk("st_bus_addr", bus_addr, 32'h0000_1008);
      chk("st_bus_wdata", bus_wdata, 32'h1234_5678);
    end
    cyc();
    @(negedge clk);
    chk1("st_c5_m_done", m_done, 1'b1);
    chk1("st_c5_bus_req", bus_req, 1'b0);
    chk("st_c5_m_rdata_kept", m_rdata, 32'hDEAD_BEEF);
    cyc();
    m_ctrl = 2'b00;
    @(negedge clk);
    chk1("st_c6_m_done_pulse", m_done, 1'b0);

    // Contention: data first, fetch right after m_done, if_valid held through a data stall.
    cyc();
    wait_min = 0; wait_max = 0;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    fetch_q.push_back(imem_word(30'h40));
    m_ctrl = 2'b01; m_addr = 32'h0000_1008;
    push_data(2'b01, 32'h0000_1008, 32'h0);
    @(negedge clk);
    chk1("ct_c0_stall_if", stall_if, 1'b1);
    cyc();
    @(negedge clk);
    chk1("ct_c1_data_first_we", bus_we, 1'b0);
    chk("ct_c1_data_first_addr", bus_addr, 32'h0000_1008);
    cyc();
    @(negedge clk);
    chk1("ct_c2_m_done", m_done, 1'b1);
    chk1("ct_c2_bus_req", bus_req, 1'b0);
    cyc();
    m_ctrl = 2'b00;
    @(negedge clk);
    chk1("ct_c3_fetch_req", bus_req, 1'b1);
    chk("ct_c3_fetch_addr", bus_addr, 32'h0000_0100);
    chk1("ct_c3_stall_mem", stall_mem, 1'b0);
    chk1("ct_c3_stall_if", stall_if, 1'b1);
    cyc();
    wait_min = 2; wait_max = 2;
    if_req = 1'b0;
    m_ctrl = 2'b01; m_addr = 32'h0000_1005;
    push_data(2'b01, 32'h0000_1005, 32'h0);
    @(negedge clk);
    chk1("ct_c4_if_valid", if_valid, 1'b1);
    chk1("ct_c4_stall_mem", stall_mem, 1'b1);
    for (int c = 5; c <= 7; c++) begin
      cyc();
      @(negedge clk);
      chk1("ct_if_valid_held", if_valid, 1'b1);
    end
    cyc();
    @(negedge clk);
    chk1("ct_c8_m_done", m_done, 1'b1);
    chk1("ct_c8_if_valid", if_valid, 1'b1);
    cyc();
    m_ctrl = 2'b00;
    @(negedge clk);
    chk1("ct_c9_if_valid_cleared", if_valid, 1'b0);
    chk1("ct_c9_bus_req", bus_req, 1'b0);

    // Ack on the timeout boundary completes normally.
    cyc();
    wait_min = 14; wait_max = 14;
    m_ctrl = 2'b01; m_addr = 32'h0000_1030;
    push_data(2'b01, 32'h0000_1030, 32'h0);
    @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      cyc();
      @(negedge clk);
    end
    chk1("bd_c15_bus_req", bus_req, 1'b1);
    chk1("bd_c15_bus_ack", bus_ack, 1'b1);
    cyc();
    @(negedge clk);
    chk1("bd_c16_m_done", m_done, 1'b1);
    chk1("bd_c16_bus_err", bus_err, 1'b0);
    cyc();
    m_ctrl = 2'b00;
    @(negedge clk);
    chk1("bd_c17_bus_err", bus_err, 1'b0);
    chk1("bd_c17_stall_mem", stall_mem, 1'b0);

    // Timeout: ack never comes.
    cyc();
    wait_min = 1000; wait_max = 1000;
    m_ctrl = 2'b10; m_addr = 32'h0000_1010; m_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    for (int c = 1; c <= 15; c++) begin
      cyc();
      @(negedge clk);
      chk1("to_bus_req_pending", bus_req, 1'b1);
    end
    chk1("to_c15_bus_err", bus_err, 1'b0);
    cyc();
    @(negedge clk);
    chk1("to_err_bus_req", bus_req, 1'b0);
    chk1("to_err_bus_err", bus_err, 1'b1);
    chk1("to_err_stall_mem", stall_mem, 1'b1);
    chk1("to_err_stall_if", stall_if, 1'b1);
    cyc();
    m_ctrl = 2'b00;
    repeat (4) cyc();
    @(negedge clk);
    chk1("to_hold_stall_mem", stall_mem, 1'b1);
    chk1("to_hold_stall_if", stall_if, 1'b1);
    chk1("to_hold_bus_err", bus_err, 1'b1);
    chk1("to_hold_bus_req", bus_req, 1'b0);
    cyc();
    reset = 1'b0;
    m_ctrl = 2'b10;
    flush_model();
    @(negedge clk);
    chk1("to_rst_stall_mem", stall_mem, 1'b0);
    chk1("to_rst_stall_if", stall_if, 1'b0);
    cyc();
    @(negedge clk);
    chk_all_zero("to_rst");
    cyc();
    reset = 1'b1;
    m_ctrl = 2'b00;
    wait_min = 0; wait_max = 0;

    // Reset mid-access, then a late ack that must be ignored.
    cyc();
    slave_on = 1'b0;
    bus_ack = 1'b0;
    m_ctrl = 2'b01; m_addr = 32'h0000_1020;
    push_data(2'b01, 32'h0000_1020, 32'h0);
    cyc();
    @(negedge clk);
    chk1("rm_c1_bus_req", bus_req, 1'b1);
    cyc();
    reset = 1'b0;
    flush_model();
    @(negedge clk);
    chk1("rm_c2_stall_mem_forced", stall_mem, 1'b0);
    cyc();
    reset = 1'b1;
    m_ctrl = 2'b00;
    @(negedge clk);
    chk1("rm_c3_bus_req_dropped", bus_req, 1'b0);
    cyc();
    bus_ack = 1'b1;
    bus_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    chk1("rm_c4_stall_mem", stall_mem, 1'b0);
    cyc();
    bus_ack = 1'b0;
    @(negedge clk);
    chk1("rm_c5_m_done", m_done, 1'b0);
    chk1("rm_c5_bus_req", bus_req, 1'b0);
    chk("rm_c5_m_rdata", m_rdata, 32'h0);
    cyc();
    slave_on = 1'b1;
    cyc();
    run_op(2'b01, 32'h0000_1008, 32'h0);

    // Random mix: continuous fetch stream against random loads/stores and wait states.
    wait_min = 0; wait_max = 3;
    if_addr = 32'h0000_0200;
    fetch_q.push_back(imem_word(if_addr[31:2]));
    if_req = 1'b1;
    fetch_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] ctrl;
      logic [31:0] addr;
      ctrl = 2'($urandom_range(3, 1));
      addr = 32'h0000_1000 + {26'b0, 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0))};
      run_op(ctrl, addr, $urandom);
      repeat ($urandom_range(2, 0)) cyc();
    end
    cyc();
    fetch_en = 1'b0;
    if_req = 1'b0;
    repeat (20) cyc();
    fetch_q.delete();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk1("end_bus_err", bus_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between the instruction-fetch stage and the MEM stage of the 5-stage pipeline.
- The MEM stage request comes directly from the EX/MEM register outputs (M control bits, ALU result, write data).
- Generates the stall signals that freeze the pipeline registers until each access completes.
- Data accesses have priority over fetches; a bus timeout latches a sticky error and freezes the pipeline.

Parameters:
- TIMEOUT, 15, cycles with bus_req high and no bus_ack before entering ERR (1..255).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising edge of clk)
- if_req  input  1  fetch stage wants an instruction
- if_addr  input  32  fetch address (PC)
- if_rdata  output  32  fetched instruction
- if_valid  output  1  if_rdata valid; held until consumed
- m_ctrl  input  2  from EX/MEM M field: bit1 MemWrite, bit0 MemRead
- m_addr  input  32  from EX/MEM ALU result
- m_wdata  input  32  from EX/MEM store data
- m_rdata  output  32  load data
- m_done  output  1  one-cycle pulse: data access complete
- stall_mem  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- stall_if  output  1  freeze PC, IF/ID (insert bubble into ID/EX)
- bus_req  output  1  memory request
- bus_we  output  1  1 = write
- bus_addr  output  32  word address, bits[1:0] forced 0
- bus_wdata  output  32  write data
- bus_ack  input  1  access complete this cycle
- bus_rdata  input  32  read data, valid with bus_ack
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0 at edge): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, if_rdata, if_valid, m_rdata, m_done, bus_err = 0; timeout counter = 0. stall_mem and stall_if are forced 0 while reset=0.
- Reset mid-access: bus_req drops at that edge. A late bus_ack arriving in IDLE is ignored.
- FSM states: IDLE, D_ACC, I_ACC, ERR. All bus outputs are registered.
- IDLE, data request: if m_ctrl!=0 and m_done=0, go to D_ACC. Latch bus_addr={m_addr[31:2],2'b00}, bus_wdata=m_wdata, bus_we=m_ctrl[1]; set bus_req=1.
  - m_ctrl=11 is treated as a write.
- IDLE, fetch request: else if if_req=1 and if_valid=0, go to I_ACC. bus_addr={if_addr[31:2],2'b00}, bus_we=0, bus_req=1.
- IDLE, no request: bus_req=0.
- D_ACC / I_ACC: bus_req and bus outputs held stable until bus_ack.
  - On bus_ack: bus_req=0, return to IDLE, counter cleared.
  - D_ACC completion: m_done=1 for exactly the next cycle; m_rdata=bus_rdata on reads, unchanged on writes.
  - I_ACC completion: if_rdata=bus_rdata, if_valid=1.
- Timeout counter: increments each cycle in D_ACC/I_ACC without ack. When it reaches TIMEOUT, go to ERR.
  - bus_ack in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- ERR: bus_req=0, bus_err=1, stall_mem=1 and stall_if=1 held; exit only by reset.
- if_valid: set on fetch completion; cleared at the first edge where stall_mem=0 (instruction consumed into IF/ID). While if_valid=1 no new fetch starts.
- m_done: cleared unconditionally one cycle after it is set.
- Stall equations (combinational, outside ERR):
  - stall_mem = (m_ctrl!=0) & ~m_done
  - stall_if = stall_mem | (if_req & ~if_valid)
- Latency, zero-wait bus:
  - Data op: m_ctrl seen at cycle 0, bus_req at cycle 1, ack at cycle 1, m_done at cycle 2. Stall during cycles 0-1; pipeline advances at the end of cycle 2.
  - Fetch: 2 cycles, same pattern.
- Priority: when a data and a fetch request are both pending in IDLE, data wins. A fetch in progress is never aborted; a data request waits for it to finish.

Test Plan:
- Load, zero-wait ack: m_ctrl=01, m_addr=0x0000_1006, bus_rdata=0xDEAD_BEEF -> bus_addr=0x0000_1004, bus_we=0. m_rdata=0xDEAD_BEEF with m_done=1 at cycle 2. stall_mem=1 in cycles 0-1 and 0 in cycle 2.
- Store with 3 wait cycles: m_ctrl=10, m_wdata=0x1234_5678 -> bus_req high 4 cycles with stable addr/data, bus_we=1. m_done pulses once; m_rdata unchanged.
- Contention: if_req=1 and m_ctrl=01 both arrive in IDLE -> data access issued first, fetch issued the cycle after m_done. if_valid held through the data stall and cleared on the first stall_mem=0 edge.
- Timeout, TIMEOUT=15, bus_ack stuck 0 -> ERR after 15 cycles: bus_req=0, bus_err=1, both stalls 1. Stays there until reset=0, after which all outputs are 0.
- Ack on the boundary: bus_ack asserted in the same cycle the counter reaches 15 -> normal completion, bus_err=0.
- Reset mid-access: reset=0 during D_ACC, then bus_ack=1 one cycle after reset releases -> no m_done, bus_req=0, state IDLE. m_ctrl=00 after reset leaves stall_mem=0.
